// File: rtl/hazard_ctrl.sv
// Central pipeline controller for the 5-stage core: load-use stall, branch flush,
// debug halt, and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int ADDR_W       = 5,
  parameter int LOAD_STALL   = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] id_read_addr_1,
  input  logic [ADDR_W-1:0] id_read_addr_2,
  input  logic              id_read_en_1,
  input  logic              id_read_en_2,
  input  logic              ex_reg_write_enable,
  input  logic              ex_reg_write_select,
  input  logic [ADDR_W-1:0] ex_reg_write_addr,
  input  logic              mem_branch_taken,
  input  logic              halt,
  output logic              stall_flag,
  output logic              branch_flag,
  output logic              pc_write_enable,
  output logic              pc_select,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count,
  output logic [1:0]        state_o
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  // A single-cycle stall/flush never leaves RUN, and its reload value is then zero.
  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL - 1);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [1:0] STALL_NEXT   = (LOAD_STALL > 1) ? ST_STALL : ST_RUN;
  localparam logic [1:0] FLUSH_NEXT   = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             hz_s;
  logic             stall_inc_s, flush_inc_s;
  logic             stall_flag_s, branch_flag_s, pc_write_enable_s, pc_select_s;

  // Load-use detection; x0 is hardwired to zero so it is never a real dependency.
  always_comb begin
    hz_s = 1'b0;
    if (ex_reg_write_enable && ex_reg_write_select && (ex_reg_write_addr != {ADDR_W{1'b0}})) begin
      hz_s = (id_read_en_1 && (id_read_addr_1 == ex_reg_write_addr)) ||
             (id_read_en_2 && (id_read_addr_2 == ex_reg_write_addr));
    end else begin
      hz_s = 1'b0;
    end
  end

  // Control decode: priority rst > halt > branch > hazard, outputs act in the detect cycle.
  always_comb begin
    state_d           = state_q;
    rem_d             = rem_q;
    stall_inc_s       = 1'b0;
    flush_inc_s       = 1'b0;
    stall_flag_s      = 1'b0;
    branch_flag_s     = 1'b0;
    pc_write_enable_s = 1'b1;
    pc_select_s       = 1'b0;
    if (rst) begin
      branch_flag_s     = 1'b1;
      pc_write_enable_s = 1'b0;
    end else if (halt) begin
      stall_flag_s      = 1'b1;
      pc_write_enable_s = 1'b0;
      state_d           = ST_HALT;
      rem_d             = 3'd0;
    end else if (mem_branch_taken && ((state_q == ST_RUN) || (state_q == ST_STALL))) begin
      // A branch resolving during a stall discards the stall: the stalled instruction is wrong-path.
      branch_flag_s = 1'b1;
      pc_select_s   = 1'b1;
      flush_inc_s   = 1'b1;
      state_d       = FLUSH_NEXT;
      rem_d         = FLUSH_RELOAD;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hz_s) begin
            stall_flag_s      = 1'b1;
            pc_write_enable_s = 1'b0;
            stall_inc_s       = 1'b1;
            state_d           = STALL_NEXT;
            rem_d             = STALL_RELOAD;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_STALL: begin
          stall_flag_s      = 1'b1;
          pc_write_enable_s = 1'b0;
          stall_inc_s       = 1'b1;
          if (rem_q <= 3'd1) begin
            state_d = ST_RUN;
            rem_d   = 3'd0;
          end else begin
            rem_d = rem_q - 3'd1;
          end
        end
        ST_FLUSH: begin
          branch_flag_s = 1'b1;
          if (rem_q <= 3'd1) begin
            state_d = ST_RUN;
            rem_d   = 3'd0;
          end else begin
            rem_d = rem_q - 3'd1;
          end
        end
        ST_HALT: begin
          stall_flag_s      = 1'b1;
          pc_write_enable_s = 1'b0;
          state_d           = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          rem_d   = 3'd0;
        end
      endcase
    end
    stall_count_d = stall_inc_s ? sat_inc(stall_count_q) : stall_count_q;
    flush_count_d = flush_inc_s ? sat_inc(flush_count_q) : flush_count_q;
  end

  // State, remaining-cycle and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      rem_q         <= 3'd0;
      stall_count_q <= {CNT_W{1'b0}};
      flush_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_flag      = stall_flag_s;
  assign branch_flag     = branch_flag_s;
  assign pc_write_enable = pc_write_enable_s;
  assign pc_select       = pc_select_s;
  assign stall_count     = stall_count_q;
  assign flush_count     = flush_count_q;
  assign state_o         = state_q;

endmodule
